// File: rtl/rv_pipe_pkg.sv
// rtl/rv_pipe_pkg.sv - shared RV32 opcode, field and bubble constants for the fetch/X pipe
package rv_pipe_pkg;

    localparam logic [4:0] OP_R       = 5'b01100;
    localparam logic [4:0] OP_I_ARITH = 5'b00100;
    localparam logic [4:0] OP_I_LOAD  = 5'b00000;
    localparam logic [4:0] OP_S       = 5'b01000;
    localparam logic [4:0] OP_B       = 5'b11000;
    localparam logic [4:0] OP_JAL     = 5'b11011;
    localparam logic [4:0] OP_JALR    = 5'b11001;
    localparam logic [4:0] OP_LUI     = 5'b01101;
    localparam logic [4:0] OP_AUIPC   = 5'b00101;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    localparam int OP_LSB  = 2;
    localparam int RD_LSB  = 7;
    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;

    function automatic logic uses_rs1(input logic [4:0] op);
        return (op == OP_R) || (op == OP_I_ARITH) || (op == OP_I_LOAD) ||
               (op == OP_S) || (op == OP_B) || (op == OP_JALR);
    endfunction

    function automatic logic uses_rs2(input logic [4:0] op);
        return (op == OP_R) || (op == OP_S) || (op == OP_B);
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - combinational load-use hazard check between F and X
module load_use_detect
    import rv_pipe_pkg::*;
(
    input  logic [31:0] inst_F,
    input  logic [31:0] inst_X,
    input  logic        x_valid,
    output logic        stall_F
);

    logic [4:0] op_f, op_x, rd_x, rs1_f, rs2_f;
    logic       hit_rs1, hit_rs2;

    assign op_f  = inst_F[OP_LSB  +: 5];
    assign op_x  = inst_X[OP_LSB  +: 5];
    assign rd_x  = inst_X[RD_LSB  +: 5];
    assign rs1_f = inst_F[RS1_LSB +: 5];
    assign rs2_f = inst_F[RS2_LSB +: 5];

    assign hit_rs1 = uses_rs1(op_f) && (rs1_f == rd_x);
    assign hit_rs2 = uses_rs2(op_f) && (rs2_f == rd_x);

    // A load to x0 never produces a value anyone waits for.
    assign stall_F = x_valid && (op_x == OP_I_LOAD) && (rd_x != 5'd0) && (hit_rs1 || hit_rs2);

endmodule

// File: rtl/fetch_x_pipe.sv
// rtl/fetch_x_pipe.sv - fetch stage and F->X register; load-use interlock under LOAD_USE_STALL_EN
module fetch_x_pipe
    import rv_pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = NOP_INST
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        hold,
    input  logic        pc_sel,
    input  logic [31:0] alu_out,
    output logic [31:0] inst_F,
    output logic [31:0] inst_X,
    output logic [31:0] pc_X,
    output logic        x_valid,
    output logic        stall_F
);

    logic [31:0] pc_f;

    assign imem_addr = pc_f;
    assign inst_F    = imem_rdata;

`ifdef LOAD_USE_STALL_EN
    load_use_detect u_load_use_detect (
        .inst_F  (inst_F),
        .inst_X  (inst_X),
        .x_valid (x_valid),
        .stall_F (stall_F)
    );
`else
    assign stall_F = 1'b0;
`endif

    // Redirect beats hold so a taken branch seen during a memory wait is not lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_f    <= RESET_PC;
            inst_X  <= NOP;
            pc_X    <= 32'h0;
            x_valid <= 1'b0;
        end else if (pc_sel) begin
            pc_f    <= alu_out & ~32'h1;
            inst_X  <= NOP;
            pc_X    <= 32'h0;
            x_valid <= 1'b0;
        end else if (hold) begin
            pc_f    <= pc_f;
        end else if (stall_F) begin
            inst_X  <= NOP;
            pc_X    <= 32'h0;
            x_valid <= 1'b0;
        end else begin
            pc_f    <= pc_f + 32'd4;
            inst_X  <= inst_F;
            pc_X    <= pc_f;
            x_valid <= 1'b1;
        end
    end

endmodule
